icache_debug_loader: RTL
========================

# icache_debug_loader

Writer for the instruction cache's debug port. It accepts a byte stream from the debug host, assembles little-endian 32-bit instructions, and writes them to consecutive word addresses through the cache's `write_en` / `debug_addr` / `debug_input` port. An optional pass reads every word back over `debug_data` and compares it. `busy` holds the pipeline (bubble in all stages) while a load is in progress.

## Interface
- `CNT_W`, 12: width of `word_count`; a load writes at most 2^CNT_W−1 words.
- `VERIFY`, 1: 1 enables the read-back compare pass; 0 goes from the last write straight to DONE.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset: synchronous and active-low.
- `start`  in  1  one-cycle pulse; sampled only in IDLE.
- `base_addr`  in  30  word address [31:2] of the first instruction; latched on `start`.
- `word_count`  in  CNT_W  number of words to load; latched on `start`.
- `in_valid`  in  1  `in_byte` is valid.
- `in_byte`  in  8  stream byte, least-significant byte of each word first.
- `in_ready`  out  1  loader accepts a byte; a transfer occurs when `in_valid` and `in_ready` are both high.
- `write_en`  out  1  cache debug write strobe.
- `debug_addr`  out  30  cache debug word address, used for both write and read.
- `debug_input`  out  32  write data.
- `debug_data`  in  32  cache debug read data; valid one cycle after `debug_addr`.
- `busy`  out  1  high in every state except IDLE; drives the pipeline hold.
- `done`  out  1  one-cycle pulse at the end of a load.
- `error`  out  1  a verify mismatch occurred; sticky until the next accepted `start`.
- `err_addr`  out  30  word address of the first mismatch.

## Operation
- States: IDLE, COLLECT, WRITE, RD_ADDR, RD_CMP, DONE.
- **IDLE**
  - On `start`, latch `base_addr` and `word_count`; clear `idx`, byte counter, `error` and `err_addr`.
  - If `word_count` = 0, go to DONE; otherwise go to COLLECT.
- **COLLECT**
  - `in_ready` = 1.
  - Each transfer places `in_byte` into bits [8·b+7 : 8·b] of the assembly register, where b is the 2-bit byte counter.
  - The transfer with b = 3 goes to WRITE.
- **WRITE** (exactly one cycle)
  - `write_en` = 1, `debug_addr` = `base` + `idx` (mod 2^30, wraps silently), `debug_input` = assembled word.
  - Then `idx` increments. If `idx` now equals `word_count`, go to RD_ADDR with `idx` cleared when `VERIFY` = 1, or to DONE when `VERIFY` = 0. Otherwise return to COLLECT.
- **RD_ADDR**
  - Drive `debug_addr` = `base` + `idx`; go to RD_CMP.
- **RD_CMP**
  - Hold `debug_addr`.
  - Compare `debug_data` against the expected word, which is the stored copy in a 2^CNT_W-deep shadow buffer filled during WRITE.
  - On mismatch: set `error`, latch `err_addr`, go to DONE.
  - On match: increment `idx`; go to DONE when the last word has been checked, otherwise to RD_ADDR.
- **DONE**
  - `done` = 1 for one cycle; go to IDLE.
- `start` outside IDLE is ignored.
- `in_byte` presented outside COLLECT is not consumed.

## Timing
- Reset values:
  - State = IDLE.
  - `in_ready`, `write_en`, `busy`, `done`, `error` = 0.
  - `debug_addr`, `debug_input`, `err_addr` = 0.
- `busy` rises in the cycle after `start` is accepted. It falls in the cycle after DONE.
- Write latency:
  - `write_en` is high in the cycle immediately after the 4th byte transfer.
  - `in_ready` is 0 during that cycle.
  - Best case is 5 cycles per word.
- Verify costs 2 cycles per word.
- Minimum load length is 5·N + 2·N + 2 cycles from `start` to `done` (2 for IDLE→… and DONE).
- `word_count` = 0: `done` is high 2 cycles after `start`, with no writes and no reads.
- Reset asserted mid-load:
  - Next cycle is IDLE with all outputs at reset values.
  - The partial word is discarded.
  - Words already written remain in the cache.
- `in_valid` dropping mid-word stalls COLLECT indefinitely; there is no timeout.

## Structure
- Shared package `debug_pkg`:
  - state enum `ldr_state_t`
  - constant `BYTES_PER_WORD` = 4
  - address type `waddr_t` = logic [29:0]
- Sub-module `word_assembler`: byte counter plus 32-bit shift/insert register. Outputs `word`, `word_valid`.
- Shadow buffer: inferred RAM inside the loader.

## Test plan
- **Single word**
  - Stimulus: `base` = 0x10, N = 1, bytes 0x13, 0x00, 0x50, 0x00, no stalls.
  - Response: one `write_en` with addr 0x10 and data 0x00500013; verify passes; `done` pulse; `error` = 0.
- **Multi-word with stalls**
  - Stimulus: N = 3, random `in_valid` gaps.
  - Response: 3 writes at `base`, `base`+1, `base`+2 with correct words; `in_ready` = 0 in every WRITE cycle.
- **Mismatch**
  - Stimulus: cache model corrupts word 1 on read-back.
  - Response: `error` = 1, `err_addr` = `base`+1, `done` pulses right after the compare of word 1, and word 2 is not read.
- **Boundary**
  - Stimulus: N = 0.
  - Response: `done` 2 cycles after `start`, no `write_en`.
  - Stimulus: `base` = 0x3FFFFFFF, N = 2.
  - Response: second write goes to addr 0x00000000.
- **Reset and ignored start**
  - Stimulus: `rst_n` = 0 after 2 bytes of word 0.
  - Response: next cycle `busy` = 0 and outputs at reset values; a fresh load afterwards works.
  - Stimulus: `start` pulsed while `busy` = 1.
  - Response: ignored, and the in-progress load is unaffected.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared types for the instruction-cache debug loader.
package debug_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef logic [29:0] waddr_t;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        RD_ADDR,
        RD_CMP,
        DONE
    } ldr_state_t;

endpackage

// File: rtl/icache_debug_loader_if.sv
// Byte-stream input and cache debug port of the loader, bundled as one interface.
interface icache_debug_loader_if;
    import debug_pkg::*;

    logic         in_valid;
    logic [7:0]   in_byte;
    logic         in_ready;
    logic         write_en;
    waddr_t       debug_addr;
    logic [31:0]  debug_input;
    logic [31:0]  debug_data;

    modport master (
        input  in_valid,
        input  in_byte,
        output in_ready,
        output write_en,
        output debug_addr,
        output debug_input,
        input  debug_data
    );

    modport slave (
        output in_valid,
        output in_byte,
        input  in_ready,
        input  write_en,
        input  debug_addr,
        input  debug_input,
        output debug_data
    );

endinterface

// File: rtl/word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_valid marks the
// transfer that supplies the last byte, with that byte already merged into word.
module word_assembler
    import debug_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  b;
    logic [31:0] acc;

    always_comb begin
        word = acc;
        word[{b, 3'b000} +: 8] = byte_in;
    end

    assign word_valid = byte_en && (b == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            b   <= '0;
            acc <= '0;
        end else if (byte_en) begin
            b   <= b + 2'd1;
            acc <= word;
        end
    end

endmodule

// File: rtl/icache_debug_loader.sv
// Loads a host byte stream into the instruction cache through its debug port,
// optionally reading every word back and comparing against a shadow copy.
//
// state   | meaning
// IDLE    | waiting for start
// COLLECT | accepting stream bytes for the current word
// WRITE   | one-cycle cache write of the assembled word
// RD_ADDR | presenting read address for verify
// RD_CMP  | comparing read data with shadow copy
// DONE    | end of load, done pulses next cycle
module icache_debug_loader
    import debug_pkg::*;
#(
    parameter int CNT_W  = 12,
    parameter bit VERIFY = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  waddr_t                base_addr,
    input  logic [CNT_W-1:0]      word_count,
    icache_debug_loader_if.master dbg,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output waddr_t                err_addr
);

    ldr_state_t       state;
    waddr_t           base_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] idx_inc;
    logic [31:0]      word;
    logic             word_valid;
    logic             xfer;
    logic             clear_asm;
    logic [31:0]      exp_word;
    logic [31:0]      shadow [2**CNT_W];

    assign xfer      = dbg.in_valid && dbg.in_ready;
    assign clear_asm = (state == IDLE) && start;
    assign idx_inc   = idx + CNT_W'(1);

    word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear_asm),
        .byte_en    (xfer),
        .byte_in    (dbg.in_byte),
        .word       (word),
        .word_valid (word_valid)
    );

    // Shadow copy holds what was written so verify does not depend on the host resending.
    always_ff @(posedge clk) begin
        if (state == WRITE)
            shadow[idx] <= dbg.debug_input;
    end

    always_ff @(posedge clk) begin
        if (state == RD_ADDR)
            exp_word <= shadow[idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            base_r          <= '0;
            count_r         <= '0;
            idx             <= '0;
            dbg.in_ready    <= 1'b0;
            dbg.write_en    <= 1'b0;
            dbg.debug_addr  <= '0;
            dbg.debug_input <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            err_addr        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_r   <= base_addr;
                        count_r  <= word_count;
                        idx      <= '0;
                        error    <= 1'b0;
                        err_addr <= '0;
                        busy     <= 1'b1;
                        if (word_count == '0) begin
                            state <= DONE;
                        end else begin
                            state        <= COLLECT;
                            dbg.in_ready <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (word_valid) begin
                        state           <= WRITE;
                        dbg.in_ready    <= 1'b0;
                        dbg.write_en    <= 1'b1;
                        dbg.debug_addr  <= base_r + waddr_t'(idx);
                        dbg.debug_input <= word;
                    end
                end
                WRITE: begin
                    dbg.write_en <= 1'b0;
                    if (idx_inc == count_r) begin
                        if (VERIFY) begin
                            idx            <= '0;
                            dbg.debug_addr <= base_r;
                            state          <= RD_ADDR;
                        end else begin
                            state <= DONE;
                        end
                    end else begin
                        idx          <= idx_inc;
                        dbg.in_ready <= 1'b1;
                        state        <= COLLECT;
                    end
                end
                RD_ADDR: begin
                    state <= RD_CMP;
                end
                RD_CMP: begin
                    if (dbg.debug_data != exp_word) begin
                        error    <= 1'b1;
                        err_addr <= dbg.debug_addr;
                        state    <= DONE;
                    end else if (idx_inc == count_r) begin
                        state <= DONE;
                    end else begin
                        idx            <= idx_inc;
                        dbg.debug_addr <= base_r + waddr_t'(idx_inc);
                        state          <= RD_ADDR;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
